// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port word SRAM behind a req/ready handshake, 1-cycle read latency and an
// out-of-range err pulse. Define SRAM_INIT_EN to zero-fill storage after every reset.
module sram_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in_data,
    output logic              ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

`ifdef SRAM_INIT_EN
    typedef enum logic [1:0] {RESET_HOLD = 2'd0, INIT = 2'd1, IDLE = 2'd2} state_e;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
`else
    typedef enum logic {RESET_HOLD = 1'b0, IDLE = 1'b1} state_e;
`endif

    state_e              state_q, state_d;
    logic                ready_q;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we_s;
    logic [IDX_W-1:0]    mem_idx_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic                accept_s;
    logic                in_range_s;
    logic [IDX_W-1:0]    addr_idx_s;

    // ready_q is only ever high in IDLE, so it alone qualifies acceptance
    assign accept_s   = req & ready_q;
    assign in_range_s = ({1'b0, address} < DEPTH_L);
    assign addr_idx_s = address[IDX_W-1:0];

    // Next-state, storage write port and response generation
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        mem_we_s    = 1'b0;
        mem_idx_s   = addr_idx_s;
        mem_wdata_s = in_data;
`ifdef SRAM_INIT_EN
        init_cnt_d  = init_cnt_q;
`endif
        case (state_q)
            RESET_HOLD: begin
`ifdef SRAM_INIT_EN
                state_d = INIT;
`else
                state_d = IDLE;
`endif
            end
`ifdef SRAM_INIT_EN
            INIT: begin
                mem_we_s    = 1'b1;
                mem_idx_s   = init_cnt_q;
                mem_wdata_s = '0;
                if (init_cnt_q == LAST_IDX) begin
                    state_d    = IDLE;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
`endif
            IDLE: begin
                if (accept_s) begin
                    if (!in_range_s) begin
                        err_d = 1'b1;
                    end else if (we) begin
                        mem_we_s = 1'b1;
                    end else begin
                        out_data_d  = mem_q[addr_idx_s];
                        out_valid_d = 1'b1;
                    end
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = RESET_HOLD;
            end
        endcase
    end

    // Control and output registers; reset aborts any pending response or init sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_HOLD;
            ready_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef SRAM_INIT_EN
            init_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d == IDLE);
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
`ifdef SRAM_INIT_EN
            init_cnt_q  <= init_cnt_d;
`endif
        end
    end

    // Storage array has no reset so its contents survive rst
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_idx_s] <= mem_wdata_s;
        end
    end

    assign ready     = ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: table vectors, random traffic against a word-array model,
// and hand sequences for reset abort, reset release / init sweep and a 16-bit instance.
module tb_sram_ctrl;
    localparam int DEPTH = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req, we;
    logic [7:0] address, in_data;
    logic       ready, out_valid, err;
    logic [7:0] out_data;

    logic        req_b, we_b;
    logic [3:0]  addr_b;
    logic [15:0] din_b, dout_b;
    logic        ready_b, valid_b, err_b;

    sram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .address(address), .in_data(in_data),
        .ready(ready), .out_data(out_data), .out_valid(out_valid), .err(err)
    );

    sram_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .address(addr_b), .in_data(din_b),
        .ready(ready_b), .out_data(dout_b), .out_valid(valid_b), .err(err_b)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_data;

    typedef struct {
        bit         r;
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        bit         ev;
        bit         ee;
        logic [7:0] ed;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
        req = r; we = w; address = a; in_data = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    // reference: words in an array, outputs derived from the access rules
    task automatic model_step(input bit r, input bit w, input int a, input logic [7:0] d,
                              output bit ev, output bit ee);
        ev = 1'b0; ee = 1'b0;
        if (r) begin
            if (a >= DEPTH) ee = 1'b1;
            else if (w) m_mem[a] = d;
            else begin ev = 1'b1; m_data = m_mem[a]; end
        end
    endtask

    task automatic txn(input bit r, input bit w, input int a, input logic [7:0] d, input string tag);
        bit ev, ee;
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        model_step(r, w, a, d, ev, ee);
        drive(r, w, a[7:0], d);
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
        check({tag, "_err"}, {31'd0, err}, {31'd0, ee});
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, m_data});
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 40) begin @(posedge clk); #1; n++; end
        check(tag, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; address = 8'd0; in_data = 8'd0;
        req_b = 1'b0; we_b = 1'b0; addr_b = 4'd0; din_b = 16'd0;
        m_data = 8'd0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;

        vecs[0]  = '{1'b1, 1'b1, 8'd3,   8'h5A, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'd3,   8'h00, 1'b1, 1'b0, 8'h5A};
        vecs[2]  = '{1'b0, 1'b0, 8'd3,   8'h00, 1'b0, 1'b0, 8'h5A};
        vecs[3]  = '{1'b1, 1'b1, 8'd0,   8'd90, 1'b0, 1'b0, 8'h5A};
        vecs[4]  = '{1'b1, 1'b1, 8'd1,   8'd80, 1'b0, 1'b0, 8'h5A};
        vecs[5]  = '{1'b1, 1'b0, 8'd0,   8'h00, 1'b1, 1'b0, 8'd90};
        vecs[6]  = '{1'b1, 1'b0, 8'd1,   8'h00, 1'b1, 1'b0, 8'd80};
        vecs[7]  = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'd80};
        vecs[8]  = '{1'b1, 1'b1, 8'd11,  8'hFF, 1'b0, 1'b1, 8'd80};
        vecs[9]  = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'd80};
        vecs[10] = '{1'b1, 1'b1, 8'd16,  8'hFF, 1'b0, 1'b1, 8'd80};
        vecs[11] = '{1'b1, 1'b0, 8'd200, 8'h00, 1'b0, 1'b1, 8'd80};
        vecs[12] = '{1'b0, 1'b1, 8'd10,  8'hEE, 1'b0, 1'b0, 8'd80};
        vecs[13] = '{1'b1, 1'b0, 8'd10,  8'h00, 1'b1, 1'b0, 8'h1A};
        vecs[14] = '{1'b1, 1'b1, 8'd4,   8'h77, 1'b0, 1'b0, 8'h1A};
        vecs[15] = '{1'b1, 1'b0, 8'd4,   8'h00, 1'b1, 1'b0, 8'h77};
        vecs[16] = '{1'b0, 1'b0, 8'd4,   8'h00, 1'b0, 1'b0, 8'h77};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        rst = 1'b0;
        wait_ready("release_ready");

        for (int i = 0; i < DEPTH; i++) txn(1'b1, 1'b1, i, 8'h10 + 8'(i), "prefill");

        for (int i = 0; i < 17; i++) begin
            bit ev, ee;
            model_step(vecs[i].r, vecs[i].w, int'(vecs[i].a), vecs[i].d, ev, ee);
            drive(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
            check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].ee});
            check($sformatf("vec%0d_data", i), {24'd0, out_data}, {24'd0, vecs[i].ed});
        end

        for (int i = 0; i < DEPTH; i++) txn(1'b1, 1'b0, i, 8'h00, "sweep");

        for (int i = 0; i < 300; i++) begin
            txn($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 15)), 8'($urandom), "rand");
        end

        // read presented, reset asserted before the accepting edge
        req = 1'b1; we = 1'b0; address = 8'd2;
        #2 rst = 1'b1;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_data", {24'd0, out_data}, 32'd0);
        @(posedge clk); #1;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        check("abort_data2", {24'd0, out_data}, 32'd0);
        req = 1'b0;
        @(posedge clk); #1;
        check("abort_valid2", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        m_data = 8'd0;
        @(posedge clk); #1;
`ifdef SRAM_INIT_EN
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("init_busy%0d", i), {31'd0, ready}, 32'd0);
            @(posedge clk); #1;
        end
        check("init_done_ready", {31'd0, ready}, 32'd1);
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
`else
        check("first_edge_ready", {31'd0, ready}, 32'd1);
`endif
        for (int i = 0; i < DEPTH; i++) txn(1'b1, 1'b0, i, 8'h00, "post_rst");

        begin
            int n = 0;
            while (!ready_b && n < 40) begin @(posedge clk); #1; n++; end
            check("b_ready", {31'd0, ready_b}, 32'd1);
        end
        req_b = 1'b1; we_b = 1'b1; addr_b = 4'd15; din_b = 16'hBEEF;
        @(posedge clk); #1;
        check("b_wr_err", {31'd0, err_b}, 32'd0);
        check("b_wr_valid", {31'd0, valid_b}, 32'd0);
        we_b = 1'b0;
        @(posedge clk); #1;
        req_b = 1'b0;
        check("b_rd_valid", {31'd0, valid_b}, 32'd1);
        check("b_rd_data", {16'd0, dout_b}, 32'h0000BEEF);
        check("b_rd_err", {31'd0, err_b}, 32'd0);
        @(posedge clk); #1;
        check("b_idle_valid", {31'd0, valid_b}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
